// File: rtl/mem_arb_pkg.sv
// Shared widths, arbitration state and read-tag type for mem_arbiter.
// Lock support in the top is enabled with MEM_ARB_LOCK_EN.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

    // Round-robin choice between the two requesters: 1 means requester 1 wins.
    function automatic logic rr_pick1(logic req0, logic req1, logic rr);
        return req1 && (!req0 || rr);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of mem_arbiter, grouped with the arbiter as slave.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic              req0, req1;
    logic              wren0, wren1;
    logic [ADDR_W-1:0] address0, address1;
    logic [DATA_W-1:0] data0, data1;
    logic              lock0, lock1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, req1, wren0, wren1, address0, address1, data0, data1, lock0, lock1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data, mem_wren
    );

    modport master (
        output req0, req1, wren0, wren1, address0, address1, data0, data1, lock0, lock1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data, mem_wren
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// RD_LATENCY-deep shift register carrying {valid, owner} for each granted read.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [RD_LATENCY];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with round-robin and optional burst lock.
// Define MEM_ARB_LOCK_EN to honour lock0/lock1; otherwise arbitration is pure round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_LOCK   = 16
) (
    input logic      clock,
    input logic      reset,
    mem_arb_if.slave bus
);

    arb_state_e state_q, state_d;
    logic       rr_q, rr_d;
    logic       grant0, grant1;
    logic       free_any, free_win1;
    rd_tag_t    tag_in, tag_out;

`ifdef MEM_ARB_LOCK_EN
    localparam logic [7:0] MaxCnt = 8'(MAX_LOCK);
    logic [7:0] lock_cnt_q, lock_cnt_d;
`else
    logic unused_lock;
    assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

    assign free_any  = bus.req0 || bus.req1;
    assign free_win1 = rr_pick1(bus.req0, bus.req1, rr_q);

    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_d    = rr_q;
        state_d = state_q;
`ifdef MEM_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
`endif
        if (!reset) begin
`ifdef MEM_ARB_LOCK_EN
            if (state_q == LOCK0 && bus.req0) begin
                grant0     = 1'b1;
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (lock_cnt_d == MaxCnt) begin
                    state_d = FREE;
                    rr_d    = 1'b1;
                end else if (!bus.lock0) begin
                    state_d = FREE;
                end
            end else if (state_q == LOCK1 && bus.req1) begin
                grant1     = 1'b1;
                lock_cnt_d = lock_cnt_q + 8'd1;
                if (lock_cnt_d == MaxCnt) begin
                    state_d = FREE;
                    rr_d    = 1'b0;
                end else if (!bus.lock1) begin
                    state_d = FREE;
                end
            end else begin
                // Owner dropped its request (or no lock held): arbitrate as FREE this cycle.
                state_d = FREE;
                if (free_any) begin
                    grant0 = !free_win1;
                    grant1 = free_win1;
                    if (bus.req0 && bus.req1) rr_d = !free_win1;
                    if (grant0 && bus.lock0) begin
                        state_d    = LOCK0;
                        lock_cnt_d = 8'd1;
                    end else if (grant1 && bus.lock1) begin
                        state_d    = LOCK1;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
`else
            if (free_any) begin
                grant0 = !free_win1;
                grant1 = free_win1;
                if (bus.req0 && bus.req1) rr_d = !free_win1;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FREE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lock_cnt_q <= 8'd0;
        else       lock_cnt_q <= lock_cnt_d;
    end
`endif

    always_comb begin
        bus.gnt0        = grant0;
        bus.gnt1        = grant1;
        bus.mem_wren    = 1'b0;
        bus.mem_address = '0;
        bus.mem_data    = '0;
        if (grant0) begin
            bus.mem_wren    = bus.wren0;
            bus.mem_address = bus.address0;
            bus.mem_data    = bus.data0;
        end else if (grant1) begin
            bus.mem_wren    = bus.wren1;
            bus.mem_address = bus.address1;
            bus.mem_data    = bus.data1;
        end
    end

    assign tag_in.valid = (grant0 && !bus.wren0) || (grant1 && !bus.wren1);
    assign tag_in.owner = grant1;

    rd_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_tag_pipe (
        .clock  (clock),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign bus.rvalid0 = tag_out.valid && !tag_out.owner;
    assign bus.rvalid1 = tag_out.valid && tag_out.owner;
    assign bus.rdata   = tag_out.valid ? bus.mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and arbitration model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned MAX_LK = 4;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic clock = 1'b0;
    logic reset;
    mem_arb_if bus ();

    mem_arbiter #(
        .RD_LATENCY(RD_LAT),
        .MAX_LOCK  (MAX_LK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] q_pipe  [RD_LAT];
    rd_exp_t     sbq     [$];
    int          wlog    [$];

    // Reference arbitration: owner of the current lock (-1 none), burst length, rr favour.
    int lk_owner = -1;
    int lk_len   = 0;
    bit mrr      = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory with read-before-write and RD_LAT-cycle registered read.
    always @(posedge clock) begin
        q_pipe[0] <= mem[bus.mem_address];
        for (int i = 1; i < int'(RD_LAT); i++) q_pipe[i] <= q_pipe[i-1];
        if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    end
    assign bus.mem_q = q_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic predict(input bit r0, input bit r1, input bit l0, input bit l1, output int w);
        bit [1:0] req;
        bit [1:0] lk;
        req = {r1, r0};
        lk  = {l1, l0};
        w   = -1;
        if (lk_owner >= 0 && req[lk_owner]) begin
            w = lk_owner;
        end else begin
            lk_owner = -1;
            if (r0 && r1) begin
                w   = mrr ? 1 : 0;
                mrr = (w == 0);
            end else if (r0) begin
                w = 0;
            end else if (r1) begin
                w = 1;
            end
        end
`ifdef MEM_ARB_LOCK_EN
        if (w >= 0) begin
            if (lk_owner == w) begin
                lk_len++;
                if (lk_len >= int'(MAX_LK)) begin
                    lk_owner = -1;
                    mrr      = (w == 0);
                end else if (!lk[w]) begin
                    lk_owner = -1;
                end
            end else if (lk[w]) begin
                lk_owner = w;
                lk_len   = 1;
            end
        end
`else
        lk = lk;
`endif
    endtask

    // Called just after a rising edge; leaves just after the next one.
    task automatic step(input bit r0, input bit w0, input logic [15:0] a0, input logic [31:0] d0,
                        input bit l0, input bit r1, input bit w1, input logic [15:0] a1,
                        input logic [31:0] d1, input bit l1);
        int          w;
        bit          ew;
        logic [15:0] ea;
        logic [31:0] ed;
        bus.req0 = r0; bus.wren0 = w0; bus.address0 = a0; bus.data0 = d0; bus.lock0 = l0;
        bus.req1 = r1; bus.wren1 = w1; bus.address1 = a1; bus.data1 = d1; bus.lock1 = l1;
        @(negedge clock);
        predict(r0, r1, l0, l1, w);
        wlog.push_back(w);
        check("gnt0", 64'(bus.gnt0), 64'(w == 0));
        check("gnt1", 64'(bus.gnt1), 64'(w == 1));
        ew = 1'b0; ea = '0; ed = '0;
        if (w == 0) begin ew = w0; ea = a0; ed = d0; end
        if (w == 1) begin ew = w1; ea = a1; ed = d1; end
        check("mem_wren", 64'(bus.mem_wren), 64'(ew));
        check("mem_address", 64'(bus.mem_address), 64'(ea));
        check("mem_data", 64'(bus.mem_data), 64'(ed));
        if (w >= 0 && !ew) sbq.push_back('{owner: (w == 1), data: ref_mem[ea], due: cyc + RD_LAT});
        if (w >= 0 && ew) ref_mem[ea] = ed;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);
    endtask

    task automatic check_seq(input string name, input int start, input int exp[6], input int n);
        for (int i = 0; i < n; i++) check(name, 64'(wlog[start+i]), 64'(exp[i]));
    endtask

    // Scoreboard monitor: every cycle, match rvalid against the oldest outstanding read.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                while (sbq.size() > 0 && sbq[0].due < cyc) begin
                    check("missing_rvalid", 64'(cyc), 64'(sbq[0].due));
                    void'(sbq.pop_front());
                end
                if (bus.rvalid0 || bus.rvalid1) begin
                    if (sbq.size() == 0 || sbq[0].due != cyc) begin
                        check("unexpected_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
                    end else begin
                        rd_exp_t e;
                        e = sbq.pop_front();
                        check("rvalid0", 64'(bus.rvalid0), 64'(!e.owner));
                        check("rvalid1", 64'(bus.rvalid1), 64'(e.owner));
                        check("rdata", 64'(bus.rdata), 64'(e.data));
                    end
                end else begin
                    check("rdata_idle", 64'(bus.rdata), 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int exp_alt[6];
        int exp_lock[6];
        logic [15:0] a0, a1;
        exp_alt = '{0, 1, 0, 1, -1, -1};
`ifdef MEM_ARB_LOCK_EN
        exp_lock = '{0, 0, 0, 0, 1, 0};
`else
        exp_lock = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            ref_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        end
        mem[16'h0010]     = 32'hDEAD_BEEF;
        ref_mem[16'h0010] = 32'hDEAD_BEEF;

        // Reset with both requesters active: every output must be quiet.
        reset = 1'b1;
        bus.req0 = 1; bus.wren0 = 1; bus.address0 = 16'h1234; bus.data0 = 32'hFFFF_0000;
        bus.lock0 = 1;
        bus.req1 = 1; bus.wren1 = 0; bus.address1 = 16'h4321; bus.data1 = 32'h0000_FFFF;
        bus.lock1 = 1;
        repeat (2) @(negedge clock);
        check("rst_gnt0", 64'(bus.gnt0), 64'd0);
        check("rst_gnt1", 64'(bus.gnt1), 64'd0);
        check("rst_mem_wren", 64'(bus.mem_wren), 64'd0);
        check("rst_mem_address", 64'(bus.mem_address), 64'd0);
        check("rst_mem_data", 64'(bus.mem_data), 64'd0);
        check("rst_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single read of 0x0010.
        step(1, 0, 16'h0010, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);
        idle();

        // Both read for four cycles: alternating grants.
        start = wlog.size();
        for (int i = 0; i < 4; i++) step(1, 0, 16'(i), 32'h0, 0, 1, 0, 16'(i + 16'h100), 32'h0, 0);
        check_seq("alt_grant", start, exp_alt, 4);
        idle();

        // req0 with lock against req1 for six cycles.
        start = wlog.size();
        for (int i = 0; i < 6; i++) step(1, 0, 16'(i + 16'h40), 32'h0, 1, 1, 0, 16'h77, 32'h0, 0);
        check_seq("lock_grant", start, exp_lock, 6);
        idle();

        // Write then read back by requester 1; then read-before-write by requester 0.
        step(0, 0, 16'h0, 32'h0, 0, 1, 1, 16'h0800, 32'h1234_5678, 0);
        step(0, 0, 16'h0, 32'h0, 0, 1, 0, 16'h0800, 32'h0, 0);
        step(1, 0, 16'h0020, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);
        step(1, 1, 16'h0020, 32'hCAFE_F00D, 0, 0, 0, 16'h0, 32'h0, 0);
        step(1, 0, 16'h0020, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);
        idle();

        // Random traffic over a small address window so reads and writes collide.
        for (int n = 0; n < 400; n++) begin
            a0 = 16'($urandom_range(0, 7) * 16'h0101);
            a1 = 16'($urandom_range(0, 7) * 16'h0101);
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), a0, $urandom,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), a1, $urandom,
                 $urandom_range(0, 1) == 1);
        end
        repeat (RD_LAT + 2) idle();

        // Reset in the cycle after a granted (locked) read: that read must vanish.
        step(1, 0, 16'h0031, 32'h0, 0, 1, 0, 16'h0032, 32'h0, 0);
        step(1, 0, 16'h0033, 32'h0, 1, 0, 0, 16'h0, 32'h0, 0);
        reset = 1'b1;
        sbq.delete();
        lk_owner = -1;
        lk_len   = 0;
        mrr      = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        @(negedge clock);
        check("rst_flush_rvalid", {62'd0, bus.rvalid1, bus.rvalid0}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_state_free", 64'(dut.state_q), 64'(FREE));
        check("rst_rr_zero", 64'(dut.rr_q), 64'd0);
        repeat (RD_LAT + 2) idle();
        start = wlog.size();
        step(1, 0, 16'h0050, 32'h0, 0, 1, 0, 16'h0051, 32'h0, 0);
        check("post_rst_grant", 64'(wlog[start]), 64'd0);
        repeat (RD_LAT + 2) idle();

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
